// File: rtl/nonce_sched_pkg.sv
// Shared types for the nonce scheduler: FSM states and index widths for the
// default 4-core / 16-nonce configuration.
package nonce_sched_pkg;

  localparam int DEF_NUM_CORES  = 4;
  localparam int DEF_NUM_NONCES = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINISH
  } state_t;

  typedef logic [$clog2(DEF_NUM_NONCES)-1:0] nonce_idx_t;
  typedef logic [$clog2(DEF_NUM_CORES)-1:0]  core_sel_t;

  // Index width that never collapses to zero for single-entry configurations.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_reorder_buf.sv
// Reorder buffer: one write port per hash core, single in-order read at the
// write-back pointer with same-cycle bypass of an arriving result.
module result_reorder_buf
  import nonce_sched_pkg::*;
#(
  parameter int NUM_CORES  = DEF_NUM_CORES,
  parameter int NUM_NONCES = DEF_NUM_NONCES,
  parameter int IDX_W      = clog2_min1(DEF_NUM_NONCES)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clr,
  input  logic [NUM_CORES-1:0]             wr_en,
  input  logic [NUM_CORES-1:0][IDX_W-1:0]  wr_idx,
  input  logic [NUM_CORES-1:0][31:0]       wr_data,
  input  logic [IDX_W-1:0]                 rd_idx,
  input  logic                             rd_pop,
  output logic                             rd_valid,
  output logic [31:0]                      rd_data
);

  logic [31:0]           entry [NUM_NONCES];
  logic [NUM_NONCES-1:0] valid;
  logic [NUM_NONCES-1:0] valid_next;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    rd_valid = valid[rd_idx];
    rd_data  = entry[rd_idx];
    for (int c = 0; c < NUM_CORES; c++) begin
      if (wr_en[c] && (wr_idx[c] == rd_idx)) begin
        rd_valid = 1'b1;
        rd_data  = wr_data[c];
      end
    end
  end

  always_comb begin
    valid_next = valid;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (wr_en[c]) valid_next[wr_idx[c]] = 1'b1;
    end
    // A bypassed result is consumed the cycle it arrives, so the pop wins.
    if (rd_pop) valid_next[rd_idx] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (clr) begin
      valid <= '0;
    end else begin
      valid <= valid_next;
    end
  end

  // NOTE: the data array is not reset; valid bits alone gate every read, so resetting storage would only cost area.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CORES; c++) begin
      if (wr_en[c]) entry[wr_idx[c]] <= wr_data[c];
    end
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Dispatches a batch of nonce jobs onto a pool of hash cores and writes the
// results back to memory in nonce order.
module nonce_scheduler
  import nonce_sched_pkg::*;
#(
  parameter int NUM_CORES  = DEF_NUM_CORES,
  parameter int NUM_NONCES = DEF_NUM_NONCES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [31:0]                 nonce_base,
  input  logic [15:0]                 output_addr,
  output logic [NUM_CORES-1:0]        core_start,
  output logic [31:0]                 core_nonce,
  input  logic [NUM_CORES-1:0]        core_done,
  input  logic [NUM_CORES-1:0][31:0]  core_hash,
  output logic                        mem_we,
  output logic [15:0]                 mem_addr,
  output logic [31:0]                 mem_write_data,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int IDX_W = clog2_min1(NUM_NONCES);
  localparam int SEL_W = clog2_min1(NUM_CORES);
  localparam int DI_W  = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCES - 1);

  state_t                         state, next_state;
  logic [31:0]                    base_q;
  logic [15:0]                    addr_q;
  logic [DI_W-1:0]                di;
  logic [IDX_W-1:0]               wp;
  logic [NUM_CORES-1:0]           core_busy;
  logic [NUM_CORES-1:0][IDX_W-1:0] tag;

  logic                 accept, run;
  logic [NUM_CORES-1:0] free_mask, pick_onehot, good_done, bad_done;
  logic [SEL_W-1:0]     pick_sel;
  logic                 pick_ok, disp;
  logic [DI_W-1:0]      disp_idx;
  logic [31:0]          disp_nonce;
  logic                 rd_valid, pop;
  logic [31:0]          rd_data;

  assign accept = (state == ST_IDLE) && start;
  assign run    = (state == ST_RUN);

  // The first job is dispatched on the accepting edge itself, with all cores free.
  always_comb begin
    free_mask   = accept ? '1 : ~core_busy;
    pick_ok     = 1'b0;
    pick_sel    = '0;
    pick_onehot = '0;
    for (int c = NUM_CORES - 1; c >= 0; c--) begin
      if (free_mask[c]) begin
        pick_ok  = 1'b1;
        pick_sel = SEL_W'(c);
      end
    end
    pick_onehot[pick_sel] = pick_ok;
  end

  assign disp       = pick_ok && (accept || (run && (di < DI_W'(NUM_NONCES))));
  assign disp_idx   = accept ? '0 : di;
  assign disp_nonce = (accept ? nonce_base : base_q) + 32'(disp_idx);

  assign good_done = run ? (core_done & core_busy) : '0;
  assign bad_done  = core_done & ~good_done;
  assign pop       = run && rd_valid;

  result_reorder_buf #(
    .NUM_CORES (NUM_CORES),
    .NUM_NONCES(NUM_NONCES),
    .IDX_W     (IDX_W)
  ) u_reorder (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .wr_en   (good_done),
    .wr_idx  (tag),
    .wr_data (core_hash),
    .rd_idx  (wp),
    .rd_pop  (pop),
    .rd_valid(rd_valid),
    .rd_data (rd_data)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (start) next_state = ST_RUN;
      ST_RUN:    if (pop && (wp == LAST_IDX)) next_state = ST_FINISH;
      ST_FINISH: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q         <= '0;
      addr_q         <= '0;
      di             <= '0;
      wp             <= '0;
      core_busy      <= '0;
      tag            <= '0;
      core_start     <= '0;
      core_nonce     <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      core_start <= disp ? pick_onehot : '0;
      if (disp) begin
        core_nonce    <= disp_nonce;
        tag[pick_sel] <= disp_idx[IDX_W-1:0];
      end
      di        <= (accept ? '0 : di) + DI_W'(disp);
      core_busy <= (accept ? '0 : (core_busy & ~good_done)) | (disp ? pick_onehot : '0);

      mem_we <= pop;
      if (pop) begin
        mem_addr       <= addr_q + 16'(wp);
        mem_write_data <= rd_data;
      end

      if (accept) begin
        base_q <= nonce_base;
        addr_q <= output_addr;
        wp     <= '0;
      end else if (pop) begin
        wp <= wp + IDX_W'(1);
      end

      busy <= (next_state != ST_IDLE);
      done <= (state == ST_FINISH);
      // A stray completion in the accepting cycle still counts against the new batch.
      err  <= (accept ? 1'b0 : err) | (|bad_done);
    end
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Bench for nonce_scheduler: behavioural hash cores plus a write-back scoreboard.
`timescale 1ns/1ps
module tb_nonce_scheduler;

  localparam int NC = 4;
  localparam int NN = 16;
  localparam logic [31:0] HASH_KEY = 32'hA5A5A5A5;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic                 clk = 1'b0;
  logic                 reset, start;
  logic [31:0]          nonce_base;
  logic [15:0]          output_addr;
  logic [NC-1:0]        core_start, core_done, model_done, inj_done;
  logic [31:0]          core_nonce;
  logic [NC-1:0][31:0]  core_hash;
  logic                 mem_we, busy, done, err;
  logic [15:0]          mem_addr;
  logic [31:0]          mem_write_data;

  assign core_done = model_done | inj_done;

  nonce_scheduler #(.NUM_CORES(NC), .NUM_NONCES(NN)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .nonce_base    (nonce_base),
    .output_addr   (output_addr),
    .core_start    (core_start),
    .core_nonce    (core_nonce),
    .core_done     (core_done),
    .core_hash     (core_hash),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  initial forever #5 clk = ~clk;

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  wr_t         exp_q[$];
  int          st_cyc[$];
  logic [31:0] st_nonce[$];
  int          wr_cyc[$];
  logic [15:0] wr_addr[$];
  logic [31:0] wr_data[$];

  int          lat[NC];
  int          cnt[NC];
  bit          active[NC];
  logic [31:0] mnonce[NC];
  int          mjob[NC];
  bit          hold_all;
  bit          all_ready;
  int          job;
  logic [31:0] batch_base;
  logic [15:0] batch_addr;
  int          done_cnt, done_cyc, job0_fire_cyc, start_cyc;
  logic        busy_at_done;

  // Core model and write-back monitor, all sampled on the falling edge.
  initial begin
    model_done = '0;
    core_hash  = '0;
    hold_all   = 1'b0;
    for (int c = 0; c < NC; c++) begin
      lat[c] = 10; cnt[c] = 0; active[c] = 1'b0; mnonce[c] = '0; mjob[c] = -1;
    end
    forever begin
      @(negedge clk);
      if (reset) begin
        model_done = '0;
        for (int c = 0; c < NC; c++) active[c] = 1'b0;
        exp_q.delete();
      end else begin
        if (mem_we) begin
          wr_cyc.push_back(cyc);
          wr_addr.push_back(mem_addr);
          wr_data.push_back(mem_write_data);
          tests_run++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL wr_unexpected: got addr=%h data=%h, expected no write", mem_addr, mem_write_data);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (mem_addr !== e.addr || mem_write_data !== e.data) begin
              fails++;
              $display("FAIL wr_data: got addr=%h data=%h, expected addr=%h data=%h",
                       mem_addr, mem_write_data, e.addr, e.data);
            end
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc     = cyc;
          busy_at_done = busy;
        end

        model_done = '0;
        for (int c = 0; c < NC; c++) if (active[c] && cnt[c] > 0) cnt[c]--;
        all_ready = 1'b1;
        for (int c = 0; c < NC; c++) if (!(active[c] && cnt[c] == 0)) all_ready = 1'b0;
        for (int c = 0; c < NC; c++) begin
          if (active[c] && cnt[c] == 0 && (!hold_all || all_ready)) begin
            model_done[c] = 1'b1;
            core_hash[c]  = mnonce[c] ^ HASH_KEY;
            active[c]     = 1'b0;
            if (mjob[c] == 0) job0_fire_cyc = cyc;
          end
        end

        if (core_start != '0) begin
          logic [31:0] en;
          wr_t         w;
          en = batch_base + 32'(job);
          tests_run++;
          if (!$onehot(core_start) || core_nonce !== en) begin
            fails++;
            $display("FAIL core_start: got start=%b nonce=%h, expected one-hot nonce=%h", core_start, core_nonce, en);
          end
          w.addr = batch_addr + 16'(job);
          w.data = en ^ HASH_KEY;
          exp_q.push_back(w);
          st_cyc.push_back(cyc);
          st_nonce.push_back(core_nonce);
          for (int c = 0; c < NC; c++) begin
            if (core_start[c]) begin
              active[c] = 1'b1; cnt[c] = lat[c]; mnonce[c] = core_nonce; mjob[c] = job;
            end
          end
          job++;
        end
      end
    end
  end

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3, input bit hold);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    hold_all = hold;
  endtask

  task automatic begin_batch(input logic [31:0] base, input logic [15:0] addr);
    st_cyc.delete(); st_nonce.delete();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    done_cnt = 0; job = 0; job0_fire_cyc = -1;
    batch_base = base; batch_addr = addr;
    @(negedge clk);
    nonce_base = base; output_addr = addr; start = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || core_start !== 4'b0001) begin
      fails++;
      $display("FAIL first_dispatch: got busy=%b core_start=%b, expected busy=1 core_start=0001", busy, core_start);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (done_cnt !== 1) begin
      fails++;
      $display("FAIL %s done_count: got %0d, expected 1", name, done_cnt);
    end
    tests_run++;
    if (wr_cyc.size() != NN || exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s write_count: got %0d writes, %0d pending, expected %0d and 0",
               name, wr_cyc.size(), exp_q.size(), NN);
    end
    tests_run++;
    if (done_cyc !== wr_cyc[NN-1] + 1 || busy_at_done !== 1'b0) begin
      fails++;
      $display("FAIL %s done_timing: got done cycle %0d busy=%b, expected cycle %0d busy=0",
               name, done_cyc, busy_at_done, wr_cyc[NN-1] + 1);
    end
  endtask

  task automatic check_outputs_reset(input string name);
    tests_run++;
    if (core_start !== '0 || core_nonce !== '0 || mem_we !== 1'b0 || mem_addr !== '0 ||
        mem_write_data !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL %s: got start=%b nonce=%h we=%b addr=%h data=%h busy=%b done=%b err=%b, expected all zero",
               name, core_start, core_nonce, mem_we, mem_addr, mem_write_data, busy, done, err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; inj_done = '0; nonce_base = '0; output_addr = '0;
    repeat (2) @(negedge clk);
    check_outputs_reset("reset_values");
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fixed_latency();
    set_lat(10, 10, 10, 10, 1'b0);
    begin_batch(32'h0000_1000, 16'h0040);
    wait_done("fixed");
    tests_run++;
    if (wr_addr[0] !== 16'h0040 || wr_data[0] !== 32'hA5A5B5A5) begin
      fails++;
      $display("FAIL fixed_first_write: got %h/%h, expected 0040/a5a5b5a5", wr_addr[0], wr_data[0]);
    end
    tests_run++;
    if (wr_addr[NN-1] !== 16'h004F || wr_data[NN-1] !== 32'hA5A5B5AA) begin
      fails++;
      $display("FAIL fixed_last_write: got %h/%h, expected 004f/a5a5b5aa", wr_addr[NN-1], wr_data[NN-1]);
    end
    for (int k = 0; k < NC; k++) begin
      tests_run++;
      if (st_cyc[k] !== start_cyc + k) begin
        fails++;
        $display("FAIL fixed_start_cycle%0d: got %0d, expected %0d", k, st_cyc[k], start_cyc + k);
      end
    end
  endtask

  task automatic test_reverse_order();
    set_lat(20, 15, 10, 5, 1'b0);
    begin_batch(32'h0000_5000, 16'h0080);
    wait_done("reverse");
    tests_run++;
    if (wr_cyc[0] !== job0_fire_cyc + 1) begin
      fails++;
      $display("FAIL reverse_first_write: got cycle %0d, expected %0d", wr_cyc[0], job0_fire_cyc + 1);
    end
    for (int j = 1; j < NC; j++) begin
      tests_run++;
      if (wr_cyc[j] !== wr_cyc[0] + j) begin
        fails++;
        $display("FAIL reverse_burst%0d: got cycle %0d, expected %0d", j, wr_cyc[j], wr_cyc[0] + j);
      end
    end
  endtask

  task automatic test_simultaneous();
    set_lat(3, 3, 3, 3, 1'b1);
    begin_batch(32'h1234_0000, 16'h0200);
    wait_done("simul");
    for (int g = 0; g < NN / NC; g++) begin
      tests_run++;
      if (wr_cyc[g*NC+3] !== wr_cyc[g*NC] + 3) begin
        fails++;
        $display("FAIL simul_write_group%0d: got span %0d, expected 3", g, wr_cyc[g*NC+3] - wr_cyc[g*NC]);
      end
    end
    for (int g = 1; g < NN / NC; g++) begin
      tests_run++;
      if (st_cyc[g*NC+3] !== st_cyc[g*NC] + 3) begin
        fails++;
        $display("FAIL simul_redispatch%0d: got span %0d, expected 3", g, st_cyc[g*NC+3] - st_cyc[g*NC]);
      end
    end
    hold_all = 1'b0;
  endtask

  task automatic test_error_and_restart();
    set_lat(10, 10, 10, 10, 1'b0);
    begin_batch(32'h0000_7000, 16'h0300);
    inj_done = 4'b0100;
    @(negedge clk);
    inj_done = '0;
    tests_run++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL err_idle_core: got err=%b, expected 1", err);
    end
    repeat (20) @(negedge clk);
    nonce_base = 32'hDEAD_0000; output_addr = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("err_batch");
    tests_run++;
    if (err !== 1'b1 || st_cyc.size() != NN) begin
      fails++;
      $display("FAIL err_sticky: got err=%b dispatches=%0d, expected err=1 dispatches=%0d", err, st_cyc.size(), NN);
    end
  endtask

  task automatic test_wrap();
    set_lat(7, 7, 7, 7, 1'b0);
    begin_batch(32'hFFFF_FFFE, 16'hFFFE);
    tests_run++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_cleared: got err=%b, expected 0", err);
    end
    wait_done("wrap");
    tests_run++;
    if (st_nonce[2] !== 32'h0000_0000 || wr_addr[2] !== 16'h0000) begin
      fails++;
      $display("FAIL wrap_job2: got nonce=%h addr=%h, expected 00000000/0000", st_nonce[2], wr_addr[2]);
    end
    tests_run++;
    if (wr_addr[1] !== 16'hFFFF || wr_data[2] !== HASH_KEY) begin
      fails++;
      $display("FAIL wrap_neighbours: got addr1=%h data2=%h, expected ffff/%h", wr_addr[1], wr_data[2], HASH_KEY);
    end
  endtask

  task automatic test_reset_mid_batch();
    set_lat(10, 10, 10, 10, 1'b0);
    begin_batch(32'h0000_2000, 16'h0100);
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_outputs_reset("reset_async");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    begin_batch(32'h0000_3000, 16'h0500);
    wait_done("after_reset");
    tests_run++;
    if (wr_addr[0] !== 16'h0500 || wr_data[0] !== (32'h0000_3000 ^ HASH_KEY)) begin
      fails++;
      $display("FAIL after_reset_first: got %h/%h, expected 0500/%h", wr_addr[0], wr_data[0], 32'h0000_3000 ^ HASH_KEY);
    end
  endtask

  initial begin
    inj_done = '0;
    test_reset();
    test_fixed_latency();
    test_reverse_order();
    test_simultaneous();
    test_error_and_restart();
    test_wrap();
    test_reset_mid_batch();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/nonce_scheduler.md
# nonce_scheduler

Dispatches a batch of nonce jobs onto a pool of `NUM_CORES` independent SHA-256 hash cores and writes each core's 32-bit result back to memory in nonce order. Cores may finish out of order; the block reorders results before writeback. It sits between the top-level bitcoin hashing controller, which supplies start, base nonce and output address, and the replicated hash-core array and memory write port.

## Interface
Parameters:
- `NUM_CORES`, 4: number of hash cores scheduled, 1..16.
- `NUM_NONCES`, 16: jobs per batch, power of two, at least `NUM_CORES`.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: batch start request, sampled only in IDLE.
- `nonce_base`, in, 32: nonce of job 0, sampled with `start`.
- `output_addr`, in, 16: word address of job 0's result, sampled with `start`.
- `core_start`, out, `NUM_CORES`: one-hot, one-cycle start pulse to a core.
- `core_nonce`, out, 32: nonce broadcast to all cores, valid while `core_start` is nonzero.
- `core_done`, in, `NUM_CORES`: one-cycle completion pulse per core.
- `core_hash`, in, `NUM_CORES`x32: per-core result, valid with its `core_done`.
- `mem_we`, out, 1: memory write strobe.
- `mem_addr`, out, 16: memory write address.
- `mem_write_data`, out, 32: memory write data.
- `busy`, out, 1: high from the accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse after the last write.
- `err`, out, 1: sticky protocol-error flag, cleared by the next accepted `start`.

## Operation
- States: IDLE, RUN, FINISH.
  - IDLE -> RUN on `start`: latch `nonce_base` and `output_addr`; clear dispatch index `di`, write pointer `wp`, all valid bits and `err`.
  - RUN -> FINISH when `wp` wraps past `NUM_NONCES-1`.
  - FINISH -> IDLE unconditionally, pulsing `done`.
- Dispatch, at most one job per cycle in RUN while `di < NUM_NONCES`:
  - Pick the lowest-index free core.
  - Assert its `core_start` bit and drive `core_nonce = nonce_base + di`, mod 2^32.
  - Record `tag[core] = di`, mark the core busy, then increment `di`.
- Collect: for every `core_done[c]` on a busy core, write `core_hash[c]` into reorder entry `tag[c]`, set its valid bit and free the core. Any number of cores may complete in the same cycle; all are captured.
- A core freed in cycle N is dispatchable no earlier than cycle N+1.
- Writeback: when `valid[wp]` is set, assert `mem_we` with `mem_addr = output_addr + wp` (16-bit wrap) and `mem_write_data = entry[wp]`. Then clear `valid[wp]` and increment `wp`. At most one write per cycle.
- `core_done` on a non-busy core, or while in IDLE: the pulse is ignored and `err` is set.
- `start` while `busy` is ignored.

## Timing
- Reset values: `core_start=0`, `core_nonce=0`, `mem_we=0`, `mem_addr=0`, `mem_write_data=0`, `busy=0`, `done=0`, `err=0`, state IDLE.
- All outputs are registered.
- With `start` sampled at edge T:
  - `busy` and the first `core_start` are asserted in cycle T+1.
  - Core k is started in cycle T+1+k, for k < `NUM_CORES`.
- A `core_done` sampled at edge D, whose tag equals `wp`, produces `mem_we` in cycle D+1.
- The last write occupies cycle W; `done` pulses in W+1; `busy` falls in W+1.
- Reset mid-batch aborts immediately: no further `core_start` or `mem_we`, and cores are not notified.

## Structure
- Package `nonce_sched_pkg`: the state enum, the `nonce_idx_t` width `$clog2(NUM_NONCES)`, and the `core_sel_t` width `$clog2(NUM_CORES)`.
- Sub-module `result_reorder_buf`:
  - `NUM_NONCES` entries x32 plus valid bits.
  - Multi-port write (one port per core) and single in-order read at `wp`.
- The top level holds the FSM, free-core priority pick, tag registers and dispatch counter.

## Test plan
- Fixed-latency model: `NUM_CORES=4`, latency 10, `hash = nonce ^ 32'hA5A5A5A5`, `nonce_base=32'h0000_1000`, `output_addr=16'h0040`. Required response: 16 writes to 0x40..0x4F, data `0xA5A5B5A5` upward; `done` exactly once.
- Reverse-order completion: core 3 finishes first and core 0 last. Required response: no write until job 0 returns, then burst writes on consecutive cycles in index order.
- Simultaneous `core_done` on all 4 cores in one cycle. Required response: all 4 results captured, 4 back-to-back writes, freed cores redispatched one per cycle.
- Wrap: `nonce_base=32'hFFFF_FFFE`, `output_addr=16'hFFFE`. Required response: job 2 nonce is `0x00000000` and job 2 address is `0x0000`.
- `core_done[2]` while core 2 is idle, and `start` re-asserted mid-batch. Required response: `err` is set, the batch completes unchanged, and `start` has no effect.
- Assert `reset` halfway through a batch. Required response: all outputs return to reset values asynchronously; a new `start` then runs a full, correct batch.
